// File: rtl/tl_sim_sram_tap.sv
// tl_sim_sram_tap
//   TL-UL inline tap between a host port and the fabric. Requests that hit the
//   window [start_addr_i, start_addr_i + SRAM_DEPTH*4) are answered locally with
//   a fixed latency of one cycle. Everything else passes through to the fabric
//   unchanged. Accepted window writes are exported on the wr_* monitor port.
//
//   Build option: SIM_SRAM_STORAGE_EN
//     defined   - local RAM holds window data (Get returns stored words)
//     undefined - no RAM; Get returns 0, writes are acked/monitored only
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   start_addr_i              window base byte address (word aligned, static)
//   in_a_*  / in_d_*          host-side A and D channels
//   out_a_* / out_d_*         fabric-side A and D channels
//   wr_valid_o/addr_o/data_o  one-cycle pulse per accepted window write
//
//   A payload: {opcode[2:0], size[1:0], source[7:0], address[31:0], mask[3:0], data[31:0]}
//   D payload: {opcode[2:0], size[1:0], source[7:0], error, data[31:0]}
module tl_sim_sram_tap #(
    parameter int unsigned SRAM_DEPTH = 16,
    parameter int unsigned MAX_OUT    = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] start_addr_i,
    input  logic        in_a_valid_i,
    output logic        in_a_ready_o,
    input  logic [80:0] in_a_i,
    output logic        in_d_valid_o,
    input  logic        in_d_ready_i,
    output logic [45:0] in_d_o,
    output logic        out_a_valid_o,
    input  logic        out_a_ready_i,
    output logic [80:0] out_a_o,
    input  logic        out_d_valid_i,
    output logic        out_d_ready_o,
    input  logic [45:0] out_d_i,
    output logic        wr_valid_o,
    output logic [31:0] wr_addr_o,
    output logic [31:0] wr_data_o
);

    localparam int unsigned CNT_W     = $clog2(MAX_OUT + 1);
    localparam int unsigned IDX_W     = (SRAM_DEPTH > 1) ? $clog2(SRAM_DEPTH) : 1;
    localparam logic [32:0] WIN_BYTES = 33'(SRAM_DEPTH * 4);

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_PUT_PART = 3'd1;
    localparam logic [2:0] OP_GET      = 3'd4;
    localparam logic [2:0] OP_ACK      = 3'd0;
    localparam logic [2:0] OP_ACK_DATA = 3'd1;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  size;
        logic [7:0]  source;
        logic        error;
        logic [31:0] data;
    } tl_d_t;

    // A-channel fields
    logic [2:0]  a_op;
    logic [1:0]  a_size;
    logic [7:0]  a_src;
    logic [31:0] a_addr;
    logic [31:0] a_data;

    assign a_op   = in_a_i[80:78];
    assign a_size = in_a_i[77:76];
    assign a_src  = in_a_i[75:68];
    assign a_addr = in_a_i[67:36];
    assign a_data = in_a_i[31:0];

    // 33-bit compare so a window touching the top of the address space
    // does not wrap around to low addresses.
    logic hit;
    assign hit = ({1'b0, a_addr} >= {1'b0, start_addr_i}) &&
                 ({1'b0, a_addr} <  ({1'b0, start_addr_i} + WIN_BYTES));

    // State
    logic             rsp_vld_q, rsp_vld_d;
    tl_d_t            rsp_q, rsp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_valid_q;
    logic [31:0]      wr_addr_q, wr_data_q;

    logic        cnt_lt_max;
    logic        hit_fire, is_put, is_get;
    logic        out_a_fire, out_d_fire;
    logic [31:0] rd_data;

    assign cnt_lt_max = (cnt_q < CNT_W'(MAX_OUT));
    assign is_put     = (a_op == OP_PUT_FULL) || (a_op == OP_PUT_PART);
    assign is_get     = (a_op == OP_GET);

    // A-channel routing. A hit waits for the fabric to drain so that local
    // responses can never overtake outstanding fabric responses.
    always_comb begin
        if (hit) in_a_ready_o = !rsp_vld_q && (cnt_q == '0);
        else     in_a_ready_o = out_a_ready_i && !rsp_vld_q && cnt_lt_max;
        out_a_valid_o = in_a_valid_i && !hit && !rsp_vld_q && cnt_lt_max;
    end

    assign out_a_o  = in_a_i;
    assign hit_fire = in_a_valid_i && hit && in_a_ready_o;

    // D-channel mux: a held local response owns the host D channel.
    always_comb begin
        if (rsp_vld_q) begin
            in_d_valid_o  = 1'b1;
            in_d_o        = rsp_q;
            out_d_ready_o = 1'b0;
        end else begin
            in_d_valid_o  = out_d_valid_i;
            in_d_o        = out_d_i;
            out_d_ready_o = in_d_ready_i;
        end
    end

    assign out_a_fire = out_a_valid_o && out_a_ready_i;
    assign out_d_fire = out_d_valid_i && out_d_ready_o;

`ifdef SIM_SRAM_STORAGE_EN
    logic [3:0]       a_mask;
    logic [IDX_W-1:0] idx;
    logic [31:0]      mem_q [SRAM_DEPTH];

    assign a_mask  = in_a_i[35:32];
    assign idx     = IDX_W'((a_addr - start_addr_i) >> 2);
    assign rd_data = mem_q[idx];

    // RAM contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (hit_fire && is_put) begin
            for (int b = 0; b < 4; b++) begin
                if (a_mask[b]) mem_q[idx][8*b +: 8] <= a_data[8*b +: 8];
            end
        end
    end
`else
    assign rd_data = '0;
`endif

    // Next-state logic
    always_comb begin
        rsp_d        = '0;
        rsp_d.size   = a_size;
        rsp_d.source = a_src;
        if (is_get) begin
            rsp_d.opcode = OP_ACK_DATA;
            rsp_d.data   = rd_data;
        end else begin
            rsp_d.opcode = OP_ACK;
            rsp_d.error  = !is_put;
        end

        rsp_vld_d = rsp_vld_q;
        if (rsp_vld_q && in_d_ready_i) rsp_vld_d = 1'b0;
        if (hit_fire)                  rsp_vld_d = 1'b1;

        cnt_d = cnt_q;
        case ({out_a_fire, out_d_fire})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_vld_q  <= 1'b0;
            rsp_q      <= '0;
            cnt_q      <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            rsp_vld_q  <= rsp_vld_d;
            cnt_q      <= cnt_d;
            if (hit_fire) rsp_q <= rsp_d;
            wr_valid_q <= hit_fire && is_put;
            if (hit_fire && is_put) begin
                wr_addr_q <= a_addr;
                wr_data_q <= a_data;
            end
        end
    end

    assign wr_valid_o = wr_valid_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_data_o  = wr_data_q;

endmodule

// File: tb/tb_tl_sim_sram_tap.sv
module tb_tl_sim_sram_tap;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h1000_0000;
`ifdef SIM_SRAM_STORAGE_EN
    localparam bit STOR = 1'b1;
`else
    localparam bit STOR = 1'b0;
`endif

    logic        clk, rst;
    logic [31:0] start_addr;
    logic        in_a_valid, in_a_ready;
    logic [80:0] in_a;
    logic        in_d_valid, in_d_ready;
    logic [45:0] in_d;
    logic        out_a_valid, out_a_ready;
    logic [80:0] out_a;
    logic        out_d_valid, out_d_ready;
    logic [45:0] out_d;
    logic        wr_valid;
    logic [31:0] wr_addr, wr_data;

    tl_sim_sram_tap #(.SRAM_DEPTH(DEPTH), .MAX_OUT(15)) dut (
        .clk_i(clk), .rst_i(rst), .start_addr_i(start_addr),
        .in_a_valid_i(in_a_valid), .in_a_ready_o(in_a_ready), .in_a_i(in_a),
        .in_d_valid_o(in_d_valid), .in_d_ready_i(in_d_ready), .in_d_o(in_d),
        .out_a_valid_o(out_a_valid), .out_a_ready_i(out_a_ready), .out_a_o(out_a),
        .out_d_valid_i(out_d_valid), .out_d_ready_o(out_d_ready), .out_d_i(out_d),
        .wr_valid_o(wr_valid), .wr_addr_o(wr_addr), .wr_data_o(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [31:0] model [DEPTH];

    task automatic chk(input string tag, input logic [80:0] obs, input logic [80:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [80:0] pa(input logic [2:0] op, input logic [1:0] sz, input logic [7:0] src,
                                       input logic [31:0] addr, input logic [3:0] m, input logic [31:0] d);
        return {op, sz, src, addr, m, d};
    endfunction

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    // Local request; dly cycles of back-pressure on in_d_ready; second=1 presents
    // another hit while the response is held to check it stays stalled.
    task automatic hit_req(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] m,
                           input logic [31:0] d, input int dly, input bit second,
                           output logic [31:0] rdata);
        logic [7:0]  src;
        logic [1:0]  sz;
        logic [45:0] exp_d;
        logic [31:0] exp_data, merged;
        bit got, put, get;
        int w;
        src = 8'($urandom); sz = 2'($urandom);
        w   = int'((addr - BASE) >> 2);
        put = (op == 3'd0) || (op == 3'd1);
        get = (op == 3'd4);
        in_a = pa(op, sz, src, addr, m, d); in_a_valid = 1'b1; in_d_ready = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (in_a_ready) got = 1'b1;
            else cyc();
        end
        chk("hit_accept", got, 1);
        chk("hit_not_forwarded", out_a_valid, 0);
        cyc();
        in_a_valid = 1'b0;
        exp_data = (get && STOR) ? model[w] : 32'h0;
        exp_d = {get ? 3'd1 : 3'd0, sz, src, !(put || get), exp_data};
        if (put) begin
            merged = model[w];
            for (int b = 0; b < 4; b++) if (m[b]) merged[8*b +: 8] = d[8*b +: 8];
            model[w] = merged;
        end
        rdata = 32'h0;
        if (second) begin
            in_a = pa(3'd4, 2'd2, 8'h5A, BASE, 4'hF, 32'h0); in_a_valid = 1'b1;
        end
        for (int k = 0; k <= dly; k++) begin
            if (k == dly) in_d_ready = 1'b1;
            @(negedge clk);
            if (k == 0) rdata = in_d[31:0];
            chk("rsp_valid", in_d_valid, 1);
            chk("rsp_payload", in_d, exp_d);
            chk("rsp_blocks_fabric_d", out_d_ready, 0);
            if (second) chk("second_req_stalled", in_a_ready, 0);
            if (k == 0) begin
                chk("wr_pulse", wr_valid, put);
                if (put) begin
                    chk("wr_addr", wr_addr, addr);
                    chk("wr_data", wr_data, d);
                end
            end else chk("wr_single_pulse", wr_valid, 0);
            cyc();
        end
        in_a_valid = 1'b0; in_d_ready = 1'b0;
        @(negedge clk);
        chk("rsp_consumed", in_d_valid, 0);
        if (put) begin
            chk("wr_pulse_end", wr_valid, 0);
            chk("wr_addr_hold", wr_addr, addr);
        end
        cyc();
    endtask

    task automatic miss_issue(input logic [80:0] pkt);
        bit got;
        in_a = pkt; in_a_valid = 1'b1; out_a_ready = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (in_a_ready) got = 1'b1;
            else cyc();
        end
        chk("miss_accept", got, 1);
        chk("miss_out_valid", out_a_valid, 1);
        chk("miss_out_payload", out_a, pkt);
        cyc();
        in_a_valid = 1'b0;
    endtask

    task automatic miss_return(input logic [45:0] dp);
        out_d_valid = 1'b1; out_d = dp; in_d_ready = 1'b1;
        @(negedge clk);
        chk("fab_d_valid", in_d_valid, 1);
        chk("fab_d_payload", in_d, dp);
        chk("fab_d_ready", out_d_ready, 1);
        cyc();
        out_d_valid = 1'b0; in_d_ready = 1'b0;
    endtask

    // Present a request without letting it handshake; check routing outputs.
    task automatic probe(input string tag, input logic [31:0] addr, input bit exp_ready, input bit exp_fwd);
        in_a = pa(3'd4, 2'd2, 8'h11, addr, 4'hF, 32'h0); in_a_valid = 1'b1;
        @(negedge clk);
        chk({tag, "_ready"}, in_a_ready, exp_ready);
        chk({tag, "_fwd"}, out_a_valid, exp_fwd);
        in_a_valid = 1'b0;
        cyc();
    endtask

    logic [31:0] rd;
    logic [45:0] dq [$];
    logic [2:0]  bad_ops [5];
    int          r;

    initial begin
        bad_ops = '{3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        rst = 1'b1; start_addr = BASE;
        in_a_valid = 1'b0; in_a = '0; in_d_ready = 1'b0;
        out_a_ready = 1'b1; out_d_valid = 1'b0; out_d = '0;
        cyc(); cyc();
        @(negedge clk);
        chk("rst_in_d_valid", in_d_valid, 0);
        chk("rst_in_d", in_d, 0);
        chk("rst_out_a_valid", out_a_valid, 0);
        chk("rst_out_d_ready", out_d_ready, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_in_a_ready", in_a_ready, 1);
        cyc();
        rst = 1'b0;
        cyc();

        // Basic PutFull
        hit_req(3'd0, BASE, 4'hF, 32'h0000_900D, 0, 1'b0, rd);

        // PutFull then PutPartial then Get
        hit_req(3'd0, BASE + 4, 4'hF, 32'h1122_3344, 0, 1'b0, rd);
        hit_req(3'd1, BASE + 4, 4'h3, 32'hAABB_CCDD, 1, 1'b0, rd);
        hit_req(3'd4, BASE + 4, 4'hF, 32'h0, 0, 1'b0, rd);
        chk("partial_get_data", rd, STOR ? 32'h1122_CCDD : 32'h0);

        // Response held 3 cycles with a second hit waiting
        hit_req(3'd4, BASE, 4'hF, 32'h0, 3, 1'b1, rd);

        // Illegal opcode
        hit_req(3'd3, BASE + 8, 4'hF, 32'hDEAD_BEEF, 0, 1'b0, rd);

        // Misses: ordering stall of hits until the fabric drains
        miss_issue(pa(3'd4, 2'd2, 8'h21, 32'h2000_0000, 4'hF, 32'h0));
        miss_issue(pa(3'd0, 2'd2, 8'h22, 32'h2000_0004, 4'h5, 32'hCAFE_F00D));
        probe("hit_stall_cnt2", BASE, 1'b0, 1'b0);
        miss_return({3'd1, 2'd2, 8'h21, 1'b0, 32'h1234_5678});
        probe("hit_stall_cnt1", BASE, 1'b0, 1'b0);
        miss_return({3'd0, 2'd2, 8'h22, 1'b1, 32'h0});
        probe("hit_ready_cnt0", BASE, 1'b1, 1'b0);

        // Window boundaries (fabric not ready so nothing handshakes)
        out_a_ready = 1'b0;
        probe("last_word", BASE + DEPTH*4 - 4, 1'b1, 1'b0);
        probe("past_end", BASE + DEPTH*4, 1'b0, 1'b1);
        probe("below_base", BASE - 4, 1'b0, 1'b1);
        out_a_ready = 1'b1;

        // Outstanding limit
        for (int i = 0; i < 15; i++)
            miss_issue(pa(3'd4, 2'd2, 8'(i), 32'h3000_0000 + 32'(i*4), 4'hF, 32'h0));
        probe("miss_at_limit", 32'h3000_1000, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) miss_return({3'd1, 2'd2, 8'(i), 1'b0, 32'($urandom)});
        probe("miss_after_drain", 32'h3000_1000, 1'b1, 1'b1);

        // Randomized traffic against the reference model
        for (int i = 0; i < DEPTH; i++)
            hit_req(3'd0, BASE + 32'(i*4), 4'hF, $urandom, 0, 1'b0, rd);
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 2)
                hit_req(3'd4, BASE + 32'($urandom_range(0, DEPTH-1)*4), 4'hF, 32'h0,
                        $urandom_range(0, 2), 1'b0, rd);
            else if (r <= 6)
                hit_req((r <= 4) ? 3'd0 : 3'd1, BASE + 32'($urandom_range(0, DEPTH-1)*4),
                        4'($urandom), $urandom, $urandom_range(0, 2), 1'b0, rd);
            else if (r == 7)
                hit_req(bad_ops[$urandom_range(0, 4)], BASE + 32'($urandom_range(0, DEPTH-1)*4),
                        4'hF, $urandom, $urandom_range(0, 2), 1'b0, rd);
            else begin
                for (int k = 0; k < r - 6; k++) begin
                    miss_issue(pa(3'($urandom), 2'($urandom), 8'($urandom),
                                  32'h4000_0000 + ($urandom & 32'h00FF_FFFC), 4'($urandom), $urandom));
                    dq.push_back(46'({$urandom, $urandom}));
                end
                while (dq.size() > 0) miss_return(dq.pop_front());
            end
        end

        // Reset with a fabric request outstanding drops the counter
        miss_issue(pa(3'd4, 2'd2, 8'h77, 32'h2000_0000, 4'hF, 32'h0));
        probe("hit_stall_pre_rst", BASE, 1'b0, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        probe("hit_ready_post_rst", BASE, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tl_sim_sram_tap.md
Name: tl_sim_sram_tap

Overview:
- TL-UL inline tap placed between a host port (e.g. core data port) and the fabric.
- Requests whose address falls in a programmable window are serviced by a small local RAM; all other requests pass through to the fabric unchanged.
- Accepted writes into the window are exported on a monitor port, used to detect SW test status/termination writes in simulation.

Parameters:
- SRAM_DEPTH, 16, number of 32-bit words in the window; window size in bytes is SRAM_DEPTH*4.
- MAX_OUT, 15, maximum outstanding pass-through requests; counter width is $clog2(MAX_OUT+1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- start_addr_i  in  32  window base byte address; word-aligned; quasi-static.
- in_a_valid_i  in  1  host A-channel valid.
- in_a_ready_o  out  1  host A-channel ready.
- in_a_i  in  81  host A payload {opcode[2:0], size[1:0], source[7:0], address[31:0], mask[3:0], data[31:0]}, opcode in MSBs.
- in_d_valid_o  out  1  host D-channel valid.
- in_d_ready_i  in  1  host D-channel ready.
- in_d_o  out  46  host D payload {opcode[2:0], size[1:0], source[7:0], error, data[31:0]}.
- out_a_valid_o  out  1  fabric A valid.
- out_a_ready_i  in  1  fabric A ready.
- out_a_o  out  81  fabric A payload, same packing as in_a_i.
- out_d_valid_i  in  1  fabric D valid.
- out_d_ready_o  out  1  fabric D ready.
- out_d_i  in  46  fabric D payload, same packing as in_d_o.
- wr_valid_o  out  1  one-cycle pulse per accepted window write.
- wr_addr_o  out  32  byte address of that write.
- wr_data_o  out  32  raw a_data of that write (mask not applied).

Behaviour:
- Channel handshakes: valid/ready; a transfer occurs on a cycle where both are high.
- hit = (address >= start_addr_i) && (address < start_addr_i + SRAM_DEPTH*4); 33-bit compare, no wrap.
- Word index = (address - start_addr_i) >> 2.
- State: sram_rsp_valid flag plus held response register; out_cnt counter.
- Reset values: sram_rsp_valid=0, out_cnt=0, wr_valid_o=0, wr_addr_o=0, wr_data_o=0. RAM contents are not reset.
- Miss path:
  - out_a_valid_o = in_a_valid_i && !hit && !sram_rsp_valid && out_cnt<MAX_OUT.
  - out_a_o = in_a_i.
  - in_a_ready_o = out_a_ready_i under the same stall terms.
- Hit path:
  - in_a_ready_o = !sram_rsp_valid && out_cnt==0, so responses always return in request order.
  - On a hit handshake, the response is registered and in_d_valid_o goes high on the next cycle; latency is 1.
  - The response holds stable until in_d_ready_i; sram_rsp_valid clears on that handshake.
  - No new hit is accepted in the cycle the response is consumed.
- Hit opcodes:
  - Get (4): AccessAckData (1), data = RAM[idx], error=0.
  - PutFullData (0) / PutPartialData (1): RAM[idx] byte lanes updated per mask; AccessAck (0), data=0, error=0.
  - Any other opcode: AccessAck (0), error=1, RAM unchanged, no monitor pulse.
- Response echoes size and source of the request.
- D mux:
  - While sram_rsp_valid: in_d driven from the response register and out_d_ready_o=0.
  - Otherwise: in_d_valid_o=out_d_valid_i, in_d_o=out_d_i, out_d_ready_o=in_d_ready_i.
- out_cnt: +1 on an out A handshake, -1 on an out D handshake; simultaneous events leave it unchanged.
- Monitor port:
  - wr_valid_o=1 the cycle after a hit PutFull/PutPartial handshake.
  - wr_addr_o/wr_data_o are registered with it and hold their last value afterwards.
- Reset mid-transaction: the pending response and counter are dropped; the fabric is expected to be reset together.

Optional Feature:
- Macro SIM_SRAM_STORAGE_EN.
- Defined: RAM instantiated and behaves as above.
- Undefined: no RAM; Get hits return data=0, writes are acknowledged and monitored but not stored. All handshake, latency and monitor behaviour is identical.

Test Plan:
- Reset with start_addr_i=0x1000_0000 -> all outputs 0, in_a_ready_o=1.
- Hit PutFull addr 0x1000_0000 data 0x0000_900D mask 0xF -> next cycle in_d_valid_o=1 with opcode 0, error=0; wr_valid_o pulses with addr 0x1000_0000, data 0x0000_900D.
- PutPartial 0x1000_0004 data 0xAABBCCDD mask 0x3 after PutFull 0x11223344, then Get -> returns 0x1122CCDD (storage enabled) or 0 (storage disabled).
- Miss Get 0x2000_0000 -> forwarded unchanged on out_a; fabric D returned unchanged; hit request stalls (in_a_ready_o=0) until out_cnt==0.
- in_d_ready_i held low 3 cycles after a hit -> response stable for 3 cycles; second request stalled; out_d_ready_o=0 throughout.
- Hit with opcode 3 -> error=1, no wr_valid_o pulse; address start+SRAM_DEPTH*4 (one past end) is forwarded to out_a.
